match_filter_ctrl: RTL and testbench
====================================

Name: match_filter_ctrl

Overview:
Control and sequencing block for the correlating match filter in the inband receive path. Holds a host-writable shadow copy of the filter configuration: 12 coefficient words, length and threshold. Commits the shadow copy to the filter only on a sample boundary, and gates co_valid while the filter is reloading. Also services the filter's match/ack handshake and keeps match statistics with a sample-count timestamp.

Parameters:
NUM_WORDS, 12, number of 32-bit coefficient words; 2 bits per tap, up to 192 taps.
MAX_LEN, 192, largest legal co_length.
HOLDOFF, 16, number of rxstrobe samples after a counted match during which further matches are acked but not counted.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
cfg_wr  in  1  register write strobe
cfg_rd  in  1  register read strobe
cfg_addr  in  5  register address
cfg_wdata  in  32  write data
cfg_rdata  out  32  read data, valid the cycle after cfg_rd
cfg_rvalid  out  1  read data valid pulse
rxstrobe  in  1  sample strobe shared with the filter
match  in  1  match flag from the filter
co_bus  out  384  active coefficients; co_k = co_bus[32k+31:32k]
co_length  out  8  active tap count
threshhold  out  32  active match threshold
co_valid  out  1  filter enable
ack  out  1  match acknowledge pulse to the filter
match_event  out  1  one-cycle pulse per counted match
match_count  out  16  counted matches, saturating
match_ts  out  32  sample counter value latched at the last counted match
cfg_err  out  1  sticky: illegal commit attempted

Behaviour:
Reset (reset==0 at clk edge): every register and output is 0; state = DISABLED. Reset applied mid-commit abandons the commit.

Register map:
- 0..11: shadow coefficient words, R/W.
- 12: shadow length [7:0], R/W.
- 13: shadow threshold, R/W.
- 14: control, write-only. bit0 = commit, bit1 = disable, bit2 = clear stats, bit3 = clear cfg_err.
- 14 read: status {24'b0, cfg_err, 1'b0, state[1:0], 4'b0}.
- 15: match_count, RO.
- 16: match_ts, RO.
- Any other address: reads 0, writes ignored.
- Read latency: exactly 1 cycle.
- cfg_wr and cfg_rd in the same cycle: both performed; the read returns the old value.

Sample counter: 32-bit, increments on every rxstrobe, wraps 0xFFFFFFFF -> 0.

FSM (2-bit state; DISABLED=0, COMMIT_WAIT=1, ACTIVE=2):
- DISABLED: co_valid=0.
  - Commit with shadow length in 1..MAX_LEN -> COMMIT_WAIT.
  - Commit with illegal length (0 or >MAX_LEN): set cfg_err, stay in DISABLED.
- COMMIT_WAIT: co_valid=0.
  - On the first cycle with rxstrobe=1, copy shadow -> active (co_bus, co_length, threshhold) and go to ACTIVE.
  - The copy uses shadow contents before that edge; a write in the same cycle is not included.
  - Disable here -> DISABLED with no copy; disable has priority over the strobe.
- ACTIVE: co_valid=1.
  - Legal commit -> COMMIT_WAIT; co_valid falls the next cycle and the active values are held until the copy.
  - Illegal commit: set cfg_err, stay in ACTIVE.
  - Disable -> DISABLED.
- Commit and disable bits both set in one write: disable wins.

Match handshake:
- Condition: match==1, state==ACTIVE, and no ack in the previous cycle.
- Response: ack=1 for exactly one cycle, asserted the cycle after match is seen. The following cycle is ignored while the filter clears match.
- Counted match (holdoff counter == 0):
  - match_count increments, saturating at 0xFFFF.
  - match_ts <= sample counter.
  - match_event pulses together with ack.
  - Holdoff counter loads HOLDOFF and decrements on each rxstrobe.
- Within holdoff: ack only; no count, timestamp or event.
- match outside ACTIVE: ack only, never counted.
- Clear stats: zeroes match_count, match_ts and the holdoff counter. If it coincides with a counted match, clear wins and count = 0; ack is still issued.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> all outputs 0, status reads 0x00.
- Load/commit: write words 0..11 = 0xA5A5_0000+k, length = 64, threshold = 1000, then commit. co_valid stays 0 until rxstrobe; on that edge co_bus word 5 = 0xA5A50005 and co_length = 64; co_valid = 1 the next cycle.
- Illegal commit: length = 0 or 200 -> cfg_err = 1, state unchanged, co_valid unchanged; clearing bit3 -> cfg_err = 0.
- Recommit while ACTIVE: change word 0, commit -> co_valid drops within 1 cycle, old co_bus held until rxstrobe, then new value and co_valid = 1. A write landing on the strobe cycle is not copied.
- Match/holdoff (HOLDOFF = 16): match at sample 100 -> one-cycle ack, match_count = 1, match_ts = 100. Second match 5 samples later -> ack only, count stays 1. Third match at sample 130 -> count = 2, ts = 130.
- Saturation and clear: force count to 0xFFFF -> another match keeps 0xFFFF. Clear stats together with a match -> count 0 and ack still pulses.

Source files
------------

// File: rtl/match_filter_ctrl.sv
// Match filter control: shadow/active coefficient config with sample-aligned commit,
// match/ack handshake, and holdoff-filtered match statistics.
module match_filter_ctrl #(
  parameter int NUM_WORDS = 12,
  parameter int MAX_LEN   = 192,
  parameter int HOLDOFF   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_wr,
  input  logic                      cfg_rd,
  input  logic [4:0]                cfg_addr,
  input  logic [31:0]               cfg_wdata,
  output logic [31:0]               cfg_rdata,
  output logic                      cfg_rvalid,
  input  logic                      rxstrobe,
  input  logic                      match,
  output logic [32*NUM_WORDS-1:0]   co_bus,
  output logic [7:0]                co_length,
  output logic [31:0]               threshhold,
  output logic                      co_valid,
  output logic                      ack,
  output logic                      match_event,
  output logic [15:0]               match_count,
  output logic [31:0]               match_ts,
  output logic                      cfg_err
);
  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {DISABLED = 2'd0, COMMIT_WAIT = 2'd1, ACTIVE = 2'd2} state_t;
  state_t state, state_nx;

  logic [NUM_WORDS-1:0][31:0] shadow;
  logic [7:0]  sh_len;
  logic [31:0] sh_thr;
  logic [31:0] sample_cnt;
  logic [HW-1:0] holdoff;
  logic [31:0] rd_mux;
  logic ctl_wr, commit, dis, clr_stats, clr_err, len_ok;
  logic load, err_set, take, counted;

  assign ctl_wr    = cfg_wr && (cfg_addr == 5'd14);
  assign commit    = ctl_wr && cfg_wdata[0];
  assign dis       = ctl_wr && cfg_wdata[1];
  assign clr_stats = ctl_wr && cfg_wdata[2];
  assign clr_err   = ctl_wr && cfg_wdata[3];
  assign len_ok    = (sh_len != 8'd0) && ({1'b0, sh_len} <= 9'(MAX_LEN));
  assign co_valid  = (state == ACTIVE);

  // Filter holds match high for a cycle after ack, so a live ack masks it.
  assign take    = match && !ack;
  assign counted = take && (state == ACTIVE) && (holdoff == '0);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    err_set  = commit && !dis && !len_ok;
    case (state)
      DISABLED:    if (commit && !dis && len_ok) state_nx = COMMIT_WAIT;
      COMMIT_WAIT: begin
        if (dis) state_nx = DISABLED;
        else if (rxstrobe) begin
          load     = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (dis) state_nx = DISABLED;
        else if (commit && len_ok) state_nx = COMMIT_WAIT;
      end
      default: state_nx = DISABLED;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    for (int k = 0; k < NUM_WORDS; k++)
      if (cfg_addr == 5'(k)) rd_mux = shadow[k];
    case (cfg_addr)
      5'd12:   rd_mux = {24'd0, sh_len};
      5'd13:   rd_mux = sh_thr;
      5'd14:   rd_mux = {24'd0, cfg_err, 1'b0, state, 4'd0};
      5'd15:   rd_mux = {16'd0, match_count};
      5'd16:   rd_mux = match_ts;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= DISABLED;
      shadow      <= '0;
      sh_len      <= '0;
      sh_thr      <= '0;
      co_bus      <= '0;
      co_length   <= '0;
      threshhold  <= '0;
      sample_cnt  <= '0;
      holdoff     <= '0;
      ack         <= 1'b0;
      match_event <= 1'b0;
      match_count <= '0;
      match_ts    <= '0;
      cfg_err     <= 1'b0;
      cfg_rdata   <= '0;
      cfg_rvalid  <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_wr) begin
        for (int k = 0; k < NUM_WORDS; k++)
          if (cfg_addr == 5'(k)) shadow[k] <= cfg_wdata;
        if (cfg_addr == 5'd12) sh_len <= cfg_wdata[7:0];
        if (cfg_addr == 5'd13) sh_thr <= cfg_wdata;
      end
      // Copy sees pre-edge shadow, so a same-cycle write misses this commit.
      if (load) begin
        co_bus     <= shadow;
        co_length  <= sh_len;
        threshhold <= sh_thr;
      end
      if (rxstrobe) sample_cnt <= sample_cnt + 32'd1;
      if (err_set) cfg_err <= 1'b1;
      else if (clr_err) cfg_err <= 1'b0;

      ack         <= take;
      match_event <= counted && !clr_stats;
      if (clr_stats) begin
        match_count <= '0;
        match_ts    <= '0;
        holdoff     <= '0;
      end else if (counted) begin
        if (match_count != 16'hFFFF) match_count <= match_count + 16'd1;
        match_ts <= sample_cnt;
        holdoff  <= HW'(HOLDOFF);
      end else if (rxstrobe && holdoff != '0) begin
        holdoff <= holdoff - HW'(1);
      end

      cfg_rvalid <= cfg_rd;
      cfg_rdata  <= cfg_rd ? rd_mux : 32'd0;
    end
  end
endmodule

// File: tb/tb_match_filter_ctrl.sv
// Directed bench for match_filter_ctrl: register/commit vector table plus
// hand sequences for commit timing, match holdoff, saturation and clear.
module tb_match_filter_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_wr, cfg_rd, rxstrobe, match;
  logic [4:0]   cfg_addr;
  logic [31:0]  cfg_wdata, cfg_rdata, threshhold, match_ts;
  logic         cfg_rvalid, co_valid, ack, match_event, cfg_err;
  logic [383:0] co_bus;
  logic [7:0]   co_length;
  logic [15:0]  match_count;

  int nvec = 0;
  int nerr = 0;
  int s    = 0;

  always #5 clk = ~clk;

  match_filter_ctrl dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .rxstrobe(rxstrobe), .match(match), .co_bus(co_bus), .co_length(co_length),
    .threshhold(threshhold), .co_valid(co_valid), .ack(ack), .match_event(match_event),
    .match_count(match_count), .match_ts(match_ts), .cfg_err(cfg_err)
  );

  typedef struct {
    logic        wr, rd;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        strobe;
    logic [31:0] exp_rdata;
    logic        exp_valid, exp_err;
    logic [7:0]  exp_len;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic w, logic r, logic [4:0] a, logic [31:0] d, logic st,
                              logic [31:0] erd, logic ev, logic ee, logic [7:0] el);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.wdata = d; v.strobe = st;
    v.exp_rdata = erd; v.exp_valid = ev; v.exp_err = ee; v.exp_len = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [4:0] a, input logic [31:0] d,
                      input logic st, input logic m);
    cfg_wr = w; cfg_rd = r; cfg_addr = a; cfg_wdata = d; rxstrobe = st; match = m;
    @(posedge clk);
    #1;
    if (st) s++;
    cfg_wr = 0; cfg_rd = 0; rxstrobe = 0; match = 0;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 32'd0, 0, 0);
  endtask

  task automatic strobes_to(input int target);
    while (s < target) step(0, 0, 5'd0, 32'd0, 1, 0);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    step(0, 1, a, 32'd0, 0, 0);
    chk(name, cfg_rdata, exp);
  endtask

  // Counted/uncounted match: ack the cycle after match, then ignored while held.
  task automatic do_match(input string name, input logic exp_evt);
    step(0, 0, 5'd0, 32'd0, 0, 1);
    chk({name, "_ack"}, 32'(ack), 32'd1);
    chk({name, "_evt"}, 32'(match_event), 32'(exp_evt));
    step(0, 0, 5'd0, 32'd0, 0, 1);
    chk({name, "_ack_off"}, 32'(ack), 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(0, 1, 5'd14, 32'd0,          0, 32'h00,       0, 0, 8'd0);
    tbl[1]  = mk(1, 0, 5'd12, 32'd0,          0, 32'h0,        0, 0, 8'd0);
    tbl[2]  = mk(1, 0, 5'd14, 32'd1,          0, 32'h0,        0, 1, 8'd0);
    tbl[3]  = mk(0, 1, 5'd14, 32'd0,          0, 32'h80,       0, 1, 8'd0);
    tbl[4]  = mk(1, 0, 5'd14, 32'd8,          0, 32'h0,        0, 0, 8'd0);
    tbl[5]  = mk(1, 0, 5'd12, 32'd200,        0, 32'h0,        0, 0, 8'd0);
    tbl[6]  = mk(1, 0, 5'd14, 32'd1,          0, 32'h0,        0, 1, 8'd0);
    tbl[7]  = mk(1, 0, 5'd14, 32'd8,          0, 32'h0,        0, 0, 8'd0);
    tbl[8]  = mk(1, 1, 5'd12, 32'd64,         0, 32'd200,      0, 0, 8'd0);
    tbl[9]  = mk(0, 1, 5'd12, 32'd0,          0, 32'd64,       0, 0, 8'd0);
    tbl[10] = mk(1, 0, 5'd13, 32'd1000,       0, 32'h0,        0, 0, 8'd0);
    tbl[11] = mk(0, 1, 5'd13, 32'd0,          0, 32'd1000,     0, 0, 8'd0);
    tbl[12] = mk(1, 1, 5'd20, 32'hDEAD,       0, 32'h0,        0, 0, 8'd0);
    tbl[13] = mk(0, 1, 5'd16, 32'd0,          0, 32'h0,        0, 0, 8'd0);
    tbl[14] = mk(1, 0, 5'd5,  32'h12345678,   0, 32'h0,        0, 0, 8'd0);
    tbl[15] = mk(0, 1, 5'd5,  32'd0,          0, 32'h12345678, 0, 0, 8'd0);
    tbl[16] = mk(1, 0, 5'd14, 32'd3,          0, 32'h0,        0, 0, 8'd0);
    tbl[17] = mk(0, 1, 5'd14, 32'd0,          0, 32'h00,       0, 0, 8'd0);
    tbl[18] = mk(1, 0, 5'd14, 32'd1,          0, 32'h0,        0, 0, 8'd0);
    tbl[19] = mk(0, 1, 5'd14, 32'd0,          0, 32'h10,       0, 0, 8'd0);
    tbl[20] = mk(1, 0, 5'd14, 32'd2,          1, 32'h0,        0, 0, 8'd0);
    tbl[21] = mk(0, 1, 5'd14, 32'd0,          0, 32'h00,       0, 0, 8'd0);

    reset = 0; cfg_wr = 0; cfg_rd = 0; cfg_addr = 0; cfg_wdata = 0; rxstrobe = 0; match = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_co_bus_or", 32'(|co_bus), 32'd0);
    chk("rst_len", 32'(co_length), 32'd0);
    chk("rst_thr", threshhold, 32'd0);
    chk("rst_outs", {25'd0, co_valid, ack, match_event, cfg_err, cfg_rvalid, 2'd0}, 32'd0);
    chk("rst_cnt", 32'(match_count), 32'd0);
    chk("rst_ts", match_ts, 32'd0);
    chk("rst_rdata", cfg_rdata, 32'd0);
    reset = 1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].strobe, 0);
      chk($sformatf("v%0d_rvalid", i), 32'(cfg_rvalid), 32'(tbl[i].rd));
      chk($sformatf("v%0d_co_valid", i), 32'(co_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("v%0d_err", i), 32'(cfg_err), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d_len", i), 32'(co_length), 32'(tbl[i].exp_len));
      if (tbl[i].rd) chk($sformatf("v%0d_rdata", i), cfg_rdata, tbl[i].exp_rdata);
    end

    // Load and commit: copy happens only on the strobe edge.
    for (int k = 0; k < 12; k++) step(1, 0, 5'(k), 32'hA5A5_0000 + 32'(k), 0, 0);
    step(1, 0, 5'd14, 32'd1, 0, 0);
    chk("cw_valid0", 32'(co_valid), 32'd0);
    idle();
    chk("cw_valid1", 32'(co_valid), 32'd0);
    chk("cw_len_held", 32'(co_length), 32'd0);
    step(0, 0, 5'd0, 32'd0, 1, 0);
    chk("ld_word5", co_bus[5*32 +: 32], 32'hA5A50005);
    chk("ld_word11", co_bus[11*32 +: 32], 32'hA5A5000B);
    chk("ld_len", 32'(co_length), 32'd64);
    chk("ld_thr", threshhold, 32'd1000);
    chk("ld_valid", 32'(co_valid), 32'd1);

    // Illegal commit while active leaves the filter running.
    step(1, 0, 5'd12, 32'd0, 0, 0);
    step(1, 0, 5'd14, 32'd1, 0, 0);
    chk("ill_err", 32'(cfg_err), 32'd1);
    chk("ill_valid", 32'(co_valid), 32'd1);
    rd_chk("ill_status", 5'd14, 32'hA0);
    step(1, 0, 5'd14, 32'd8, 0, 0);
    chk("ill_clr", 32'(cfg_err), 32'd0);
    step(1, 0, 5'd12, 32'd64, 0, 0);

    // Recommit while active; write on the strobe cycle is not copied.
    step(1, 0, 5'd0, 32'h1111_1111, 0, 0);
    step(1, 0, 5'd14, 32'd1, 0, 0);
    chk("rc_valid_drop", 32'(co_valid), 32'd0);
    chk("rc_held0", co_bus[31:0], 32'hA5A50000);
    idle();
    chk("rc_held1", co_bus[31:0], 32'hA5A50000);
    step(1, 0, 5'd0, 32'h2222_2222, 1, 0);
    chk("rc_new", co_bus[31:0], 32'h11111111);
    chk("rc_valid", 32'(co_valid), 32'd1);
    rd_chk("rc_shadow", 5'd0, 32'h22222222);

    // Match statistics with holdoff.
    strobes_to(100);
    do_match("m1", 1);
    chk("m1_cnt", 32'(match_count), 32'd1);
    chk("m1_ts", match_ts, 32'd100);
    rd_chk("m1_rd_cnt", 5'd15, 32'd1);
    rd_chk("m1_rd_ts", 5'd16, 32'd100);
    strobes_to(105);
    do_match("m2", 0);
    chk("m2_cnt", 32'(match_count), 32'd1);
    chk("m2_ts", match_ts, 32'd100);
    strobes_to(130);
    do_match("m3", 1);
    chk("m3_cnt", 32'(match_count), 32'd2);
    chk("m3_ts", match_ts, 32'd130);

    // Saturation.
    strobes_to(150);
    force dut.match_count = 16'hFFFF;
    idle();
    release dut.match_count;
    rd_chk("sat_pre", 5'd15, 32'hFFFF);
    do_match("sat", 1);
    chk("sat_cnt", 32'(match_count), 32'hFFFF);
    chk("sat_ts", match_ts, 32'd150);

    // Clear stats coincident with a counted match.
    strobes_to(170);
    step(1, 0, 5'd14, 32'd4, 0, 1);
    chk("clr_ack", 32'(ack), 32'd1);
    chk("clr_cnt", 32'(match_count), 32'd0);
    chk("clr_ts", match_ts, 32'd0);
    step(0, 0, 5'd0, 32'd0, 0, 1);
    chk("clr_ack_off", 32'(ack), 32'd0);

    // Match outside ACTIVE: acked, never counted.
    step(1, 0, 5'd14, 32'd2, 0, 0);
    chk("dis_valid", 32'(co_valid), 32'd0);
    do_match("dis_m", 0);
    chk("dis_cnt", 32'(match_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
